// File: rtl/height_monitor.sv
// rtl/height_monitor.sv - 4-sample rounded height average with descent flag and low-altitude alarm FSM
module height_monitor #(
    parameter logic [7:0] LOW_THR   = 8'd10,
    parameter int         ALARM_CNT = 3,
    parameter logic [7:0] HYST      = 8'd4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] height_in,
    input  logic       in_valid,
    output logic [7:0] avg_height,
    output logic       avg_valid,
    output logic       descending,
    output logic       low_alarm
);

    typedef enum logic [1:0] {FILL, TRACK, ALARM} state_t;

    localparam logic [3:0] ALARM_LIM = 4'(ALARM_CNT);

    state_t      state;
    state_t      state_next;
    logic [3:0]  low_cnt;
    logic [3:0]  low_cnt_next;
    logic [3:0]  low_cnt_sat;

    logic [7:0]  win [4];
    logic [9:0]  sum;
    logic [9:0]  sum_next;
    logic [9:0]  sum_rnd;
    logic [2:0]  fill;
    logic        full_next;
    logic        new_avg;
    logic [7:0]  avg_new;
    logic        is_low;
    logic [8:0]  rel_sum;
    logic [7:0]  rel_thr;

    // Running window sum: the oldest sample leaves as the newest enters.
    // The window starts zeroed, so the same update works during fill.
    assign sum_next    = sum - {2'b00, win[3]} + {2'b00, height_in};
    assign sum_rnd     = sum_next + 10'd2;
    assign avg_new     = sum_rnd[9:2];
    assign full_next   = (fill >= 3'd3);
    assign new_avg     = in_valid && full_next;
    assign is_low      = (avg_new < LOW_THR);
    assign low_cnt_sat = (low_cnt >= ALARM_LIM) ? ALARM_LIM : low_cnt + 4'd1;

    // Release limit saturates instead of wrapping when LOW_THR+HYST exceeds 255.
    assign rel_sum = {1'b0, LOW_THR} + {1'b0, HYST};
    assign rel_thr = rel_sum[8] ? 8'hFF : rel_sum[7:0];

    // State and low-average counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FILL;
            low_cnt <= 4'd0;
        end else begin
            state   <= state_next;
            low_cnt <= low_cnt_next;
        end
    end

    // Next-state and counter logic, evaluated only when a new average is produced.
    always_comb begin
        state_next   = state;
        low_cnt_next = low_cnt;
        if (new_avg) begin
            case (state)
                FILL, TRACK: begin
                    if (is_low) begin
                        low_cnt_next = low_cnt_sat;
                        state_next   = (low_cnt_sat == ALARM_LIM) ? ALARM : TRACK;
                    end else begin
                        low_cnt_next = 4'd0;
                        state_next   = TRACK;
                    end
                end
                ALARM: begin
                    if (avg_new >= rel_thr) begin
                        low_cnt_next = 4'd0;
                        state_next   = TRACK;
                    end else if (is_low) begin
                        low_cnt_next = low_cnt_sat;
                    end else begin
                        low_cnt_next = 4'd0;
                    end
                end
                default: begin
                    low_cnt_next = 4'd0;
                    state_next   = FILL;
                end
            endcase
        end
    end

    // Sample window, fill count and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) win[i] <= 8'd0;
            sum        <= 10'd0;
            fill       <= 3'd0;
            avg_height <= 8'd0;
            avg_valid  <= 1'b0;
            descending <= 1'b0;
            low_alarm  <= 1'b0;
        end else begin
            avg_valid <= 1'b0;
            if (in_valid) begin
                win[0] <= height_in;
                win[1] <= win[0];
                win[2] <= win[1];
                win[3] <= win[2];
                sum    <= sum_next;
                if (fill != 3'd4) fill <= fill + 3'd1;
            end
            if (new_avg) begin
                avg_valid  <= 1'b1;
                avg_height <= avg_new;
                // avg_height still holds the previous average at this point.
                descending <= (state != FILL) && (avg_new < avg_height);
                low_alarm  <= (state_next == ALARM);
            end
        end
    end

endmodule

// File: tb/tb_height_monitor.sv
// tb/tb_height_monitor.sv - directed self-checking bench for height_monitor
module tb_height_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] height_in = 8'd0;
    logic       in_valid = 1'b0;
    logic [7:0] avg_height;
    logic       avg_valid;
    logic       descending;
    logic       low_alarm;

    int total = 0;
    int bad = 0;

    height_monitor dut (
        .clk        (clk),
        .rst        (rst),
        .height_in  (height_in),
        .in_valid   (in_valid),
        .avg_height (avg_height),
        .avg_valid  (avg_valid),
        .descending (descending),
        .low_alarm  (low_alarm)
    );

    always #5 clk = ~clk;

    // Drive one cycle of input, then settle just past the capturing edge.
    task automatic push(input logic v, input logic [7:0] h);
        @(negedge clk);
        in_valid  = v;
        height_in = h;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({avg_height, avg_valid, descending, low_alarm} !== 11'd0) begin
            bad++;
            $display("FAIL reset_outputs: got avg=%0d v=%0b d=%0b a=%0b want all 0",
                     avg_height, avg_valid, descending, low_alarm);
        end
    endtask

    task automatic test_fill();
        logic [7:0] s [4] = '{8'd10, 8'd11, 8'd12, 8'd13};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            push(1'b1, s[i]);
            total++;
            if (avg_valid !== 1'b0) begin
                bad++;
                $display("FAIL fill_no_valid[%0d]: got %0b want 0", i, avg_valid);
            end
        end
        push(1'b1, s[3]);
        total++;
        if (avg_valid !== 1'b1 || avg_height !== 8'd12 || descending !== 1'b0 || low_alarm !== 1'b0) begin
            bad++;
            $display("FAIL fill_first_avg: got v=%0b avg=%0d d=%0b a=%0b want v=1 avg=12 d=0 a=0",
                     avg_valid, avg_height, descending, low_alarm);
        end
        push(1'b0, 8'd0);
        total++;
        if (avg_valid !== 1'b0 || avg_height !== 8'd12) begin
            bad++;
            $display("FAIL fill_hold: got v=%0b avg=%0d want v=0 avg=12", avg_valid, avg_height);
        end
    endtask

    task automatic test_rounding();
        logic [7:0] last [4] = '{8'd1, 8'd1, 8'd2, 8'd255};
        logic [7:0] fill [4] = '{8'd1, 8'd0, 8'd0, 8'd255};
        logic [7:0] first [4] = '{8'd0, 8'd0, 8'd0, 8'd255};
        logic [7:0] want [4] = '{8'd1, 8'd0, 8'd1, 8'd255};
        for (int c = 0; c < 4; c++) begin
            do_reset();
            push(1'b1, first[c]);
            push(1'b1, fill[c]);
            push(1'b1, fill[c]);
            push(1'b1, last[c]);
            total++;
            if (avg_valid !== 1'b1 || avg_height !== want[c]) begin
                bad++;
                $display("FAIL rounding[%0d]: got v=%0b avg=%0d want v=1 avg=%0d",
                         c, avg_valid, avg_height, want[c]);
            end
        end
    endtask

    task automatic test_alarm();
        logic [7:0] rel_avg [4] = '{8'd7, 8'd10, 8'd12, 8'd14};
        logic       rel_alm [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        do_reset();
        for (int i = 0; i < 3; i++) push(1'b1, 8'd5);
        for (int i = 0; i < 3; i++) begin
            push(1'b1, 8'd5);
            total++;
            if (avg_valid !== 1'b1 || avg_height !== 8'd5 || low_alarm !== (i == 2)) begin
                bad++;
                $display("FAIL alarm_rise[%0d]: got v=%0b avg=%0d a=%0b want v=1 avg=5 a=%0b",
                         i, avg_valid, avg_height, low_alarm, (i == 2));
            end
        end
        for (int i = 0; i < 4; i++) begin
            push(1'b1, 8'd14);
            total++;
            if (avg_valid !== 1'b1 || avg_height !== rel_avg[i] || low_alarm !== rel_alm[i]
                || descending !== 1'b0) begin
                bad++;
                $display("FAIL alarm_release[%0d]: got v=%0b avg=%0d a=%0b d=%0b want v=1 avg=%0d a=%0b d=0",
                         i, avg_valid, avg_height, low_alarm, descending, rel_avg[i], rel_alm[i]);
            end
        end
    endtask

    task automatic test_descending();
        do_reset();
        for (int i = 0; i < 4; i++) push(1'b1, 8'd20);
        total++;
        if (avg_height !== 8'd20 || descending !== 1'b0) begin
            bad++;
            $display("FAIL desc_first: got avg=%0d d=%0b want avg=20 d=0", avg_height, descending);
        end
        push(1'b1, 8'd16);
        total++;
        if (avg_valid !== 1'b1 || avg_height !== 8'd19 || descending !== 1'b1) begin
            bad++;
            $display("FAIL desc_drop: got v=%0b avg=%0d d=%0b want v=1 avg=19 d=1",
                     avg_valid, avg_height, descending);
        end
        push(1'b1, 8'd24);
        total++;
        if (avg_valid !== 1'b1 || avg_height !== 8'd20 || descending !== 1'b0) begin
            bad++;
            $display("FAIL desc_rise: got v=%0b avg=%0d d=%0b want v=1 avg=20 d=0",
                     avg_valid, avg_height, descending);
        end
        push(1'b1, 8'd20);
        total++;
        if (avg_height !== 8'd20 || descending !== 1'b0) begin
            bad++;
            $display("FAIL desc_equal: got avg=%0d d=%0b want avg=20 d=0", avg_height, descending);
        end
    endtask

    task automatic test_reset_in_alarm();
        do_reset();
        for (int i = 0; i < 6; i++) push(1'b1, 8'd5);
        total++;
        if (low_alarm !== 1'b1) begin
            bad++;
            $display("FAIL rst_alarm_pre: got a=%0b want 1", low_alarm);
        end
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b1;
        height_in = 8'd40;
        @(posedge clk);
        #1;
        rst = 1'b0;
        total++;
        if ({avg_height, avg_valid, descending, low_alarm} !== 11'd0) begin
            bad++;
            $display("FAIL rst_alarm_clear: got avg=%0d v=%0b d=%0b a=%0b want all 0",
                     avg_height, avg_valid, descending, low_alarm);
        end
        for (int i = 0; i < 3; i++) begin
            push(1'b1, 8'd40);
            total++;
            if (avg_valid !== 1'b0) begin
                bad++;
                $display("FAIL rst_alarm_refill[%0d]: got v=%0b want 0", i, avg_valid);
            end
        end
        push(1'b1, 8'd40);
        total++;
        if (avg_valid !== 1'b1 || avg_height !== 8'd40 || descending !== 1'b0 || low_alarm !== 1'b0) begin
            bad++;
            $display("FAIL rst_alarm_first: got v=%0b avg=%0d d=%0b a=%0b want v=1 avg=40 d=0 a=0",
                     avg_valid, avg_height, descending, low_alarm);
        end
    endtask

    task automatic test_gapped();
        do_reset();
        for (int i = 0; i < 4; i++) push(1'b1, 8'd8);
        total++;
        if (avg_valid !== 1'b1 || avg_height !== 8'd8 || low_alarm !== 1'b0) begin
            bad++;
            $display("FAIL gap_full: got v=%0b avg=%0d a=%0b want v=1 avg=8 a=0",
                     avg_valid, avg_height, low_alarm);
        end
        push(1'b1, 8'd4);
        total++;
        if (avg_valid !== 1'b1 || avg_height !== 8'd7 || descending !== 1'b1 || low_alarm !== 1'b0) begin
            bad++;
            $display("FAIL gap_s1: got v=%0b avg=%0d d=%0b a=%0b want v=1 avg=7 d=1 a=0",
                     avg_valid, avg_height, descending, low_alarm);
        end
        push(1'b0, 8'd0);
        total++;
        if (avg_valid !== 1'b0 || avg_height !== 8'd7 || descending !== 1'b1 || low_alarm !== 1'b0) begin
            bad++;
            $display("FAIL gap_idle1: got v=%0b avg=%0d d=%0b a=%0b want v=0 avg=7 d=1 a=0",
                     avg_valid, avg_height, descending, low_alarm);
        end
        push(1'b1, 8'd4);
        total++;
        if (avg_valid !== 1'b1 || avg_height !== 8'd6 || descending !== 1'b1 || low_alarm !== 1'b1) begin
            bad++;
            $display("FAIL gap_s2: got v=%0b avg=%0d d=%0b a=%0b want v=1 avg=6 d=1 a=1",
                     avg_valid, avg_height, descending, low_alarm);
        end
        push(1'b0, 8'd0);
        total++;
        if (avg_valid !== 1'b0 || avg_height !== 8'd6 || descending !== 1'b1 || low_alarm !== 1'b1) begin
            bad++;
            $display("FAIL gap_idle2: got v=%0b avg=%0d d=%0b a=%0b want v=0 avg=6 d=1 a=1",
                     avg_valid, avg_height, descending, low_alarm);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_rounding();
        test_alarm();
        test_descending();
        test_reset_in_alarm();
        test_gapped();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/height_monitor.md
HEIGHT_MONITOR -- requirements
Module: height_monitor

Interface
REQ-001 The block SHALL have parameter LOW_THR, default 8'd10, low-altitude threshold compared against the averaged height.
REQ-002 The block SHALL have parameter ALARM_CNT, default 3, the number of consecutive low averages needed to raise the alarm (range 1..15).
REQ-003 The block SHALL have parameter HYST, default 8'd4, the hysteresis added to LOW_THR for alarm release.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port height_in, input, 8 bits: fused height sample from the sensor-fusion stage.
REQ-007 The block SHALL have port in_valid, input, 1 bit: height_in is accepted on every rising edge where in_valid=1 and rst=0.
REQ-008 The block SHALL have port avg_height, output, 8 bits: rounded mean of the last 4 accepted samples.
REQ-009 The block SHALL have port avg_valid, output, 1 bit: one-cycle pulse marking a new avg_height.
REQ-010 The block SHALL have port descending, output, 1 bit: the new average is strictly below the previous average.
REQ-011 The block SHALL have port low_alarm, output, 1 bit: level signal, asserted while in state ALARM.

Function
REQ-012 The block SHALL keep a 4-entry sample window as a shift register, with the newest sample entering and the oldest being discarded on each accepted sample.
REQ-013 The block SHALL keep a fill counter 0..4 that increments per accepted sample and saturates at 4.
REQ-014 The block SHALL compute the window sum at 10-bit width, and avg_height SHALL equal (sum + 2) >> 2, i.e. round half up; the maximum is (1020+2)>>2 = 255, with no overflow.
REQ-015 The block SHALL register all outputs; when a sample accepted at edge N completes or extends a full window, avg_valid=1 together with updated avg_height, descending and low_alarm SHALL be presented in the cycle after edge N (latency 1).
REQ-016 The block SHALL hold avg_valid at 0 while the fill count is below 4 (including after the 1st, 2nd and 3rd samples), and in any cycle following an edge with in_valid=0.
REQ-017 The block SHALL hold avg_height, descending and low_alarm at their last values between avg_valid pulses.
REQ-018 The block SHALL accept one sample per cycle when in_valid is held high continuously; there is no backpressure.
REQ-019 The block SHALL implement FSM states FILL, TRACK and ALARM.
REQ-020 The FSM SHALL transition FILL->TRACK on the edge accepting the 4th sample; that average SHALL also be evaluated against LOW_THR.
REQ-021 A new average < LOW_THR SHALL increment low_cnt, which saturates at ALARM_CNT; a new average >= LOW_THR (equality counts as not low) SHALL clear low_cnt.
REQ-022 The FSM SHALL transition TRACK->ALARM on the edge where low_cnt reaches ALARM_CNT; low_alarm SHALL then rise in the same cycle as that avg_valid pulse.
REQ-023 The FSM SHALL transition ALARM->TRACK when a new average >= LOW_THR+HYST, with the sum computed at 9 bits and the limit saturated to 255; on exit low_cnt SHALL clear and low_alarm SHALL fall in the same cycle as that avg_valid pulse.
REQ-024 Averages in [LOW_THR, LOW_THR+HYST) SHALL leave the FSM in ALARM.
REQ-025 descending SHALL be 0 on the first average after FILL; on each later average it SHALL equal (new avg < previous avg), and equal averages SHALL give 0.

Reset
REQ-026 On rst=1 at a rising edge, the block SHALL clear the window, fill count, low_cnt and previous average, and set the state to FILL.
REQ-027 On rst=1 at a rising edge, the block SHALL set avg_height=0, avg_valid=0, descending=0 and low_alarm=0 in the following cycle.
REQ-028 The block SHALL ignore a sample presented with in_valid=1 during rst=1.
REQ-029 Reset mid-fill or in ALARM SHALL discard all history, so 4 new samples are needed before the next avg_valid.

Verification
REQ-030 The bench SHALL cover fill: after reset, samples 10,11,12,13 on consecutive cycles -> no avg_valid after samples 1-3; one cycle after sample 4, avg_valid=1 with avg_height=12 (sum 46) and descending=0.
REQ-031 The bench SHALL cover rounding: windows 1,1,1,0 -> 1; 1,0,0,0 -> 0; 2,0,0,0 -> 1; 255,255,255,255 -> 255.
REQ-032 The bench SHALL cover the alarm with defaults: six samples of 5 -> averages 5,5,5; low_alarm rises with the 3rd avg_valid; then samples of 14 -> averages 7,10,12,14; low_alarm falls with avg 14, not with avg 10 or 12.
REQ-033 The bench SHALL cover descending: 20,20,20,20 then 16 -> avg 19, descending=1; then 24 -> avg 20, descending=0.
REQ-034 The bench SHALL cover reset in ALARM with in_valid high: next cycle all outputs are 0 and state is FILL; the sample during rst is not counted; the next avg_valid appears only after 4 post-reset samples.
REQ-035 The bench SHALL cover gapped input: in_valid toggling 1,0,1,0 -> avg_valid only in cycles following accepted samples once full, with low_cnt and descending unchanged in gap cycles.
